// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder backed by a small register file, with independent write and read FSMs.
// Define AXI4LITE_SLVERR_EN to answer out-of-range addresses with SLVERR instead of OKAY.
module axi4lite_slave_regfile #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4LITE_SLVERR_EN
    localparam logic [1:0] RESP_BAD  = 2'b10;
`else
    localparam logic [1:0] RESP_BAD  = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}                 r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [DATA_WIDTH-1:0] rd_val;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Ready/valid decoded purely from registered state; reset masks the readies.
    assign s_awready = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_DATA));
    assign s_wready  = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_ADDR));
    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_arready = !rst && (r_state_q == R_IDLE);
    assign s_rvalid  = (r_state_q == R_DATA);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // Write FSM: collect address and data in either order, then commit and respond.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        commit    = 1'b0;
        c_addr    = awaddr_q;
        c_data    = wdata_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    c_addr    = s_awaddr;
                    c_data    = s_wdata;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d  = s_awaddr;
                    w_state_d = W_ADDR;
                end else if (w_hs) begin
                    wdata_d   = s_wdata;
                    w_state_d = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_hs) begin
                    commit    = 1'b1;
                    c_data    = s_wdata;
                    w_state_d = W_RESP;
                end
            end
            W_DATA: begin
                if (aw_hs) begin
                    commit    = 1'b1;
                    c_addr    = s_awaddr;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit) begin
            bresp_d = addr_ok(c_addr) ? RESP_OKAY : RESP_BAD;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(c_addr) == i) regs_d[i] = c_data;
            end
        end
    end

    // Read FSM: the register file is sampled before this edge's write lands, so collisions return the old value.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_val    = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(s_araddr) == i) rd_val = regs_q[i];
        end
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = addr_ok(s_araddr) ? rd_val : '0;
                    rresp_d   = addr_ok(s_araddr) ? RESP_OKAY : RESP_BAD;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile: a 4-register and a 3-register instance share one bus.
module tb_axi4lite_slave_regfile;

    localparam int LIMIT = 20;
`ifdef AXI4LITE_SLVERR_EN
    localparam logic [1:0] EXP_BAD = 2'b10;
`else
    localparam logic [1:0] EXP_BAD = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] s_awaddr, s_araddr;
    logic       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [7:0] s_wdata;

    logic       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0] s_bresp, s_rresp;
    logic [7:0] s_rdata;

    logic       s_awready_3, s_wready_3, s_bvalid_3, s_arready_3, s_rvalid_3;
    logic [1:0] s_bresp_3, s_rresp_3;
    logic [7:0] s_rdata_3;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd, rd3;
    logic [1:0] rr, rr3, br, br3;

    always #5 clk = ~clk;

    axi4lite_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(4)) u_dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    axi4lite_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready_3),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready_3),
        .s_bresp(s_bresp_3), .s_bvalid(s_bvalid_3), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready_3),
        .s_rdata(s_rdata_3), .s_rresp(s_rresp_3), .s_rvalid(s_rvalid_3), .s_rready(s_rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound(input string tag, input int n);
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s: waited %0d cycles, required < %0d", tag, n, LIMIT);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                            output logic [1:0] b, output logic [1:0] b3);
        int n;
        s_awaddr = a; s_wdata = d; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        n = 0;
        while (!(s_awready && s_wready) && n < LIMIT) begin tick(); n++; end
        bound("wr_accept", n);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < LIMIT) begin tick(); n++; end
        bound("wr_bvalid", n);
        check("wr_bvalid_lockstep", 32'(s_bvalid_3), 1);
        b = s_bresp; b3 = s_bresp_3;
        tick();
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] d, output logic [1:0] r,
                           output logic [7:0] d3, output logic [1:0] r3);
        int n;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        while (!s_arready && n < LIMIT) begin tick(); n++; end
        bound("rd_accept", n);
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < LIMIT) begin tick(); n++; end
        bound("rd_rvalid", n);
        check("rd_rvalid_lockstep", 32'(s_rvalid_3), 1);
        d = s_rdata; r = s_rresp; d3 = s_rdata_3; r3 = s_rresp_3;
        tick();
        s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_awready", 32'(s_awready), 0);
        check("rst_wready",  32'(s_wready),  0);
        check("rst_arready", 32'(s_arready), 0);
        check("rst_bvalid",  32'(s_bvalid),  0);
        check("rst_rvalid",  32'(s_rvalid),  0);
        check("rst_bresp",   32'(s_bresp),   0);
        check("rst_rresp",   32'(s_rresp),   0);
        check("rst_rdata",   32'(s_rdata),   0);
        rst = 1'b0;
        tick();
        check("idle_awready", 32'(s_awready), 1);
        check("idle_wready",  32'(s_wready),  1);
        check("idle_arready", 32'(s_arready), 1);

        // 1: AW and W together, then read back with one-cycle latency
        s_awaddr = 2'd2; s_wdata = 8'h04; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t1_bvalid", 32'(s_bvalid), 1);
        check("t1_bresp",  32'(s_bresp),  0);
        check("t1_awready_resp", 32'(s_awready), 0);
        tick();
        s_bready = 1'b0;
        check("t1_bvalid_done", 32'(s_bvalid), 0);
        s_araddr = 2'd2; s_arvalid = 1'b1; s_rready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("t1_rvalid", 32'(s_rvalid), 1);
        check("t1_rdata",  32'(s_rdata),  'h04);
        check("t1_rresp",  32'(s_rresp),  0);
        tick();
        s_rready = 1'b0;
        check("t1_rvalid_done", 32'(s_rvalid), 0);

        // 2: W three cycles ahead of AW
        s_wdata = 8'h3C; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t2_wready_hold",  32'(s_wready),  0);
            check("t2_awready_hold", 32'(s_awready), 1);
            check("t2_bvalid_hold",  32'(s_bvalid),  0);
            tick();
        end
        s_awaddr = 2'd1; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("t2_bvalid", 32'(s_bvalid), 1);
        check("t2_bresp",  32'(s_bresp),  0);
        tick();
        s_bready = 1'b0;
        do_read(2'd1, rd, rr, rd3, rr3);
        check("t2_rdata", 32'(rd), 'h3C);

        // 3: B back-pressure stalls a second write
        s_awaddr = 2'd0; s_wdata = 8'h11; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        tick();
        s_awaddr = 2'd3; s_wdata = 8'h22;
        for (int k = 0; k < 5; k++) begin
            check("t3_bvalid_stall",  32'(s_bvalid),  1);
            check("t3_bresp_stall",   32'(s_bresp),   0);
            check("t3_awready_stall", 32'(s_awready), 0);
            check("t3_wready_stall",  32'(s_wready),  0);
            tick();
        end
        s_bready = 1'b1;
        check("t3_bvalid_release", 32'(s_bvalid), 1);
        tick();
        check("t3_bvalid_gap",   32'(s_bvalid),  0);
        check("t3_awready_gap",  32'(s_awready), 1);
        check("t3_wready_gap",   32'(s_wready),  1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t3_bvalid_second", 32'(s_bvalid), 1);
        tick();
        s_bready = 1'b0;
        do_read(2'd0, rd, rr, rd3, rr3);
        check("t3_rdata_reg0", 32'(rd), 'h11);
        do_read(2'd3, rd, rr, rd3, rr3);
        check("t3_rdata_reg3", 32'(rd), 'h22);

        // 4: write commit and AR to the same register on the same edge
        do_write(2'd1, 8'h55, br, br3);
        check("t4_bresp_pre", 32'(br), 0);
        s_awaddr = 2'd1; s_wdata = 8'hAA; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        s_araddr = 2'd1; s_arvalid = 1'b1; s_rready = 1'b1;
        check("t4_arready", 32'(s_arready), 1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("t4_rvalid", 32'(s_rvalid), 1);
        check("t4_rdata_old", 32'(s_rdata), 'h55);
        check("t4_bvalid", 32'(s_bvalid), 1);
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        do_read(2'd1, rd, rr, rd3, rr3);
        check("t4_rdata_new", 32'(rd), 'hAA);

        // 5: reset mid-transaction with R pending and address held
        s_awaddr = 2'd2; s_awvalid = 1'b1; s_araddr = 2'd1; s_arvalid = 1'b1; s_rready = 1'b0;
        tick();
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        check("t5_rvalid_pre",  32'(s_rvalid),  1);
        check("t5_awready_pre", 32'(s_awready), 0);
        check("t5_wready_pre",  32'(s_wready),  1);
        rst = 1'b1;
        #1;
        check("t5_awready_in_rst", 32'(s_awready), 0);
        check("t5_wready_in_rst",  32'(s_wready),  0);
        check("t5_arready_in_rst", 32'(s_arready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rvalid",  32'(s_rvalid),  0);
        check("t5_bvalid",  32'(s_bvalid),  0);
        check("t5_awready", 32'(s_awready), 1);
        check("t5_wready",  32'(s_wready),  1);
        check("t5_arready", 32'(s_arready), 1);
        check("t5_rdata",   32'(s_rdata),   0);
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), rd, rr, rd3, rr3);
            check($sformatf("t5_reg%0d_cleared", i), 32'(rd), 0);
        end

        // 6: address 3 is out of range only for the 3-register instance
        do_write(2'd3, 8'h77, br, br3);
        check("t6_bresp_in_range", 32'(br),  0);
        check("t6_bresp_oob",      32'(br3), 32'(EXP_BAD));
        do_read(2'd3, rd, rr, rd3, rr3);
        check("t6_rdata_in_range", 32'(rd),  'h77);
        check("t6_rresp_in_range", 32'(rr),  0);
        check("t6_rdata_oob",      32'(rd3), 0);
        check("t6_rresp_oob",      32'(rr3), 32'(EXP_BAD));
        for (int i = 0; i < 3; i++) begin
            do_read(2'(i), rd, rr, rd3, rr3);
            check($sformatf("t6_dut3_reg%0d_untouched", i), 32'(rd3), 0);
            check($sformatf("t6_dut3_reg%0d_rresp", i), 32'(rr3), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
